// File: rtl/para_bank_loader.sv
// rtl/para_bank_loader.sv - double-buffered parameter bank loader
//
// Streams FM_DEPTH + 5*CHANNEL_NUM signed words into the shadow bank
// (segments: rsign, bn_a, bn_b, beta, gamma, zeta) and commits the shadow
// bank to active on swap. Output arrays always show the active bank.
//
// Optional feature macro: PARA_BANK_LOADER_CHECKSUM_EN
//   adds a CHECK state that takes one trailing word which must equal the
//   modulo-2^PARA_WIDTH sum of the payload; a mismatch sets err and drops
//   the load so it can never be swapped in.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   start               pulse: begin / restart a shadow-bank load
//   in_valid, in_ready  word handshake for para_in
//   para_in             signed parameter word
//   swap                pulse: commit shadow bank (accepted in DONE only)
//   busy                FSM not idle
//   load_done           complete shadow bank awaiting swap
//   err                 sticky checksum mismatch (0 without the macro)
//   bank_sel            index of the active bank
//   rsign_para, bn_a, bn_b, beta, gamma, zeta   active-bank arrays

module para_bank_loader #(
    parameter int PARA_WIDTH  = 16,
    parameter int FM_DEPTH    = 64,
    parameter int CHANNEL_NUM = 128
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [PARA_WIDTH-1:0] para_in,
    input  logic                         swap,
    output logic                         busy,
    output logic                         load_done,
    output logic                         err,
    output logic                         bank_sel,
    output logic signed [PARA_WIDTH-1:0] rsign_para [FM_DEPTH],
    output logic signed [PARA_WIDTH-1:0] bn_a       [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] bn_b       [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] beta       [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] gamma      [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] zeta       [CHANNEL_NUM]
);

    localparam int MAX_D = (FM_DEPTH > CHANNEL_NUM) ? FM_DEPTH : CHANNEL_NUM;
    localparam int IDX_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam int FM_AW = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
    localparam int CH_AW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    localparam logic [IDX_W-1:0] FM_LAST  = IDX_W'(FM_DEPTH - 1);
    localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(CHANNEL_NUM - 1);
    localparam logic [2:0]       SEG_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       seg_q, seg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bank_sel_q, bank_sel_d;
    logic             wr_en;
    logic             restart;
    logic [IDX_W-1:0] seg_last_idx;

`ifdef PARA_BANK_LOADER_CHECKSUM_EN
    logic [PARA_WIDTH-1:0] chk_q, chk_d;
    logic                  err_q, err_d;
`endif

    // Segment 0 has its own depth; segments 1..5 share one array indexed seg-1.
    logic signed [PARA_WIDTH-1:0] rsign_mem [2][FM_DEPTH];
    logic signed [PARA_WIDTH-1:0] ch_mem    [2][5][CHANNEL_NUM];

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        idx_d      = idx_q;
        bank_sel_d = bank_sel_q;
        wr_en      = 1'b0;
        restart    = 1'b0;
        in_ready   = 1'b0;
        load_done  = 1'b0;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
        err_d      = err_q;
`endif
        seg_last_idx = (seg_q == 3'd0) ? FM_LAST : CH_LAST;

        case (state_q)
            S_IDLE: begin
                if (start) restart = 1'b1;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (start) begin
                    restart = 1'b1;
                end else if (in_valid) begin
                    wr_en = 1'b1;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
                    chk_d = chk_q + para_in;
`endif
                    if (idx_q == seg_last_idx) begin
                        idx_d = '0;
                        if (seg_q == SEG_LAST) begin
                            seg_d = 3'd0;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            seg_d = seg_q + 3'd1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (start) begin
                    restart = 1'b1;
                end else if (in_valid) begin
                    if (para_in == chk_q) begin
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_DONE: begin
                load_done = 1'b1;
                // swap has priority over a simultaneous start
                if (swap) begin
                    bank_sel_d = ~bank_sel_q;
                    state_d    = S_IDLE;
                end else if (start) begin
                    restart = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d = S_LOAD;
            seg_d   = 3'd0;
            idx_d   = '0;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
            chk_d   = '0;
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            seg_q      <= 3'd0;
            idx_q      <= '0;
            bank_sel_q <= 1'b0;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            bank_sel_q <= bank_sel_d;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
        end
    end

    // Writes only ever target the shadow bank, so the active outputs stay put.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FM_DEPTH; i++) rsign_mem[b][i] <= '0;
                for (int s = 0; s < 5; s++)
                    for (int i = 0; i < CHANNEL_NUM; i++) ch_mem[b][s][i] <= '0;
            end
        end else if (wr_en) begin
            if (seg_q == 3'd0)
                rsign_mem[~bank_sel_q][idx_q[FM_AW-1:0]] <= para_in;
            else
                ch_mem[~bank_sel_q][seg_q - 3'd1][idx_q[CH_AW-1:0]] <= para_in;
        end
    end

    assign rsign_para = rsign_mem[bank_sel_q];
    assign bn_a       = ch_mem[bank_sel_q][3'd0];
    assign bn_b       = ch_mem[bank_sel_q][3'd1];
    assign beta       = ch_mem[bank_sel_q][3'd2];
    assign gamma      = ch_mem[bank_sel_q][3'd3];
    assign zeta       = ch_mem[bank_sel_q][3'd4];

    assign busy     = (state_q != S_IDLE);
    assign bank_sel = bank_sel_q;
`ifdef PARA_BANK_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: doc/para_bank_loader.md
PARA_BANK_LOADER -- requirements
Module: para_bank_loader

Interface
REQ-001 Parameter PARA_WIDTH, default 16, bit width of every parameter word.
REQ-002 Parameter FM_DEPTH, default 64, entries in the rsign segment (segment 0).
REQ-003 Parameter CHANNEL_NUM, default 128, entries in each of the bn_a, bn_b, beta, gamma and zeta segments (segments 1..5).
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port rstn  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  single-cycle pulse that begins (or restarts) a load into the shadow bank.
REQ-007 Port in_valid  input  1  para_in holds a valid word.
REQ-008 Port in_ready  output  1  block accepts a word this cycle; a word transfers when in_valid && in_ready.
REQ-009 Port para_in  input  PARA_WIDTH  signed parameter word.
REQ-010 Port swap  input  1  single-cycle pulse that commits the loaded shadow bank to active.
REQ-011 Port busy  output  1  high when the FSM is not in IDLE.
REQ-012 Port load_done  output  1  high while a complete shadow bank awaits swap.
REQ-013 Port err  output  1  sticky checksum-mismatch flag.
REQ-014 Port bank_sel  output  1  index of the active bank.
REQ-015 Ports rsign_para (FM_DEPTH x PARA_WIDTH), bn_a, bn_b, beta, gamma, zeta (CHANNEL_NUM x PARA_WIDTH each)  output  signed arrays read from the active bank.

Function
REQ-016 Storage is two banks, each holding all six segments; the active bank is bank_sel and the shadow bank is !bank_sel.
REQ-017 FSM states are IDLE, LOAD, CHECK (present only with the macro) and DONE.
REQ-018 IDLE: in_ready=0, load_done=0; start -> LOAD with segment counter, index counter and checksum cleared and err cleared.
REQ-019 LOAD: in_ready=1; each transfer writes para_in to shadow[seg][idx] and then increments idx.
REQ-020 When idx reaches the segment length (FM_DEPTH for seg 0, CHANNEL_NUM otherwise), idx wraps to 0 and seg increments.
REQ-021 The transfer of the last word of seg 5 moves the FSM to CHECK, or to DONE when the macro is absent; total payload is FM_DEPTH+5*CHANNEL_NUM words.
REQ-022 No transfer occurs in a cycle with in_valid=0; the counters hold.
REQ-023 start in LOAD or CHECK restarts the load from seg 0 idx 0 on the next cycle, clears the checksum and discards the partial load; the active bank is unaffected.
REQ-024 DONE: in_ready=0, load_done=1; swap toggles bank_sel on the next edge and returns the FSM to IDLE (load_done falls in the same cycle).
REQ-025 swap outside DONE is ignored; start in DONE without swap -> LOAD, overwriting the shadow bank; start and swap together in DONE -> swap wins and start is ignored.
REQ-026 Output arrays change only on the edge that toggles bank_sel and are never disturbed by shadow-bank writes.
REQ-027 Counter widths are $clog2 of max(FM_DEPTH, CHANNEL_NUM) for idx and 3 bits for seg; seg never exceeds 5.

Reset
REQ-028 rstn low asynchronously forces the FSM to IDLE and clears seg, idx and the checksum.
REQ-029 rstn low drives in_ready=0, busy=0, load_done=0, err=0 and bank_sel=0, and zeroes every entry of both banks.
REQ-030 Reset asserted mid-load abandons the load; after release no output changes until a full load followed by swap.

Configuration
REQ-031 Macro PARA_BANK_LOADER_CHECKSUM_EN defined: the checksum is the modulo-2^PARA_WIDTH sum of all payload words accepted in LOAD.
REQ-032 With the macro, CHECK holds in_ready=1 and accepts exactly one trailing word; if it equals the checksum -> DONE, otherwise err=1 and -> IDLE, so no swap is possible.
REQ-033 Macro undefined: no CHECK state, no checksum logic, err tied 0, and LOAD goes directly to DONE.

Verification (FM_DEPTH=4, CHANNEL_NUM=8, PARA_WIDTH=16; payload 44 words)
REQ-034 Reset, start, 44 words 1..44 continuous valid (plus trailing word 990 with macro), then swap -> bank_sel=1, rsign_para[3]=4, bn_a[0]=5, zeta[7]=44; load_done high exactly until swap.
REQ-035 Same load with in_valid toggling every other cycle -> identical array contents; in_ready=0 in IDLE and DONE.
REQ-036 Second load of 44 words 100..143 without swap -> outputs still 1..44; after swap rsign_para[0]=100 and bank_sel=0.
REQ-037 start after 20 words, then full 44-word load and swap -> contents exactly the second stream; no word from the aborted stream remains.
REQ-038 Macro defined, trailing word 991 instead of 990 -> err=1, FSM in IDLE, later swap ignored; next start clears err.
REQ-039 rstn asserted at word 30 of a load following a committed bank -> all outputs 0, bank_sel=0, busy=0 immediately.
